axi_add_sched: RTL and testbench
================================

# axi_add_sched

Frame scheduler that shares one `axi_add` accumulator between `NUM_REQ` stream requesters. It grants one requester at a time for a whole frame of `NUM_COUNT` beats, forwards that requester's beats to the adder, and then holds the grant until the adder's result has been handed downstream. The result is tagged with the requester index. The block sits directly in front of `axi_add`; adder data and result signals pass through it, and the 7-segment result digits bypass it.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `N`, 8: data width per beat; matches the adder's `N`.
- `NUM_COUNT`, 8: beats per frame; matches the adder's `NUM_COUNT`.
- `ID_W`, `$clog2(NUM_REQ)`: width of the requester index (localparam).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_data`  in  `NUM_REQ*N`  requester beats; requester i occupies slice `[i*N +: N]`.
- `req_valid`  in  `NUM_REQ`  per-requester valid.
- `req_ready`  out  `NUM_REQ`  per-requester ready.
- `add_data`  out  `N`  beat to the adder.
- `add_valid`  out  1  beat valid to the adder (adder `s_valid`).
- `add_ready`  in  1  adder accepts a beat.
- `add_res_valid`  in  1  adder result valid (adder `m_valid`).
- `add_res_ready`  out  1  result ready to the adder (adder `m_ready`).
- `res_valid`  out  1  tagged result valid, downstream.
- `res_ready`  in  1  downstream accepts the result.
- `res_id`  out  `ID_W`  requester index that owns the current result.
- `busy`  out  1  high whenever the state is not `S_IDLE`.

## Operation
- States: `S_IDLE`, `S_FEED`, `S_WAIT_RES`.
- **`S_IDLE`**
  - All ready and valid outputs are low.
  - If any `req_valid` is high, register the grant and go to `S_FEED`.
  - The grant is the first requester at or after `rr_ptr`, searching upward with wrap-around.
- **`S_FEED`**
  - Outputs, all combinational: `add_data` = granted slice, `add_valid` = `req_valid[grant]`, `req_ready[grant]` = `add_ready`. All other `req_ready` are 0.
  - Each handshake (`add_valid & add_ready`) increments `beat_cnt`.
  - On the handshake that brings `beat_cnt` to `NUM_COUNT`, clear `beat_cnt` and go to `S_WAIT_RES`.
  - A requester that drops `req_valid` mid-frame only stalls the frame. The grant is never pre-empted.
- **`S_WAIT_RES`**
  - Outputs: `res_valid` = `add_res_valid`, `add_res_ready` = `res_ready`, `res_id` = grant.
  - On the handshake `add_res_valid & res_ready`: set `rr_ptr` = grant+1 (wrapping from `NUM_REQ-1` to 0) and go to `S_IDLE`.
- Outside `S_WAIT_RES`, `add_res_ready` and `res_valid` are 0. An adder result outside `S_WAIT_RES` is not acknowledged.
- **Widths:** `beat_cnt` is `$clog2(NUM_COUNT+1)` bits, `rr_ptr` is `ID_W` bits. Wrap is explicit, so it is correct when `NUM_REQ` is not a power of 2.
- **Reset, including mid-frame:** state goes to `S_IDLE`; `rr_ptr`, grant and `beat_cnt` go to 0. Every output is 0, and `res_id` is 0. The adder shares the same `reset`, so any partial accumulation is discarded on both sides.

## Timing
- Arbitration is registered: grant is decided in `S_IDLE`, and the first beat can transfer the next cycle.
- `S_FEED` passes data through with zero latency, one beat per cycle when the requester and adder are both ready.
- There is no same-cycle bypass from `S_WAIT_RES` to a new grant. At least one `S_IDLE` cycle separates frames.
- Minimum frame period: `NUM_COUNT` + adder latency + 2 cycles.
- A `req_valid` change during `S_IDLE` is sampled at the clock edge only.

## Configuration
- Macro: `AXI_ADD_SCHED_PRIO_EN`.
- Defined: requester 0 has absolute priority. If `req_valid[0]` is high in `S_IDLE`, it wins regardless of `rr_ptr`, and `rr_ptr` is not updated after a requester-0 frame. The other requesters use round-robin among themselves.
- Undefined: pure round-robin as described in Operation.

## Structure
- Package `axi_add_pkg` holds:
  - enum `sched_state_e` (`S_IDLE`, `S_FEED`, `S_WAIT_RES`);
  - function `rr_next(ptr, n)` for the wrap-around increment.
- One sub-module, `rr_pick`: combinational. Inputs are the request vector and a pointer; outputs are the granted index and a valid flag. It is instantiated once; under `AXI_ADD_SCHED_PRIO_EN` its result is overridden by requester 0.

## Test plan
- **Reset mid-frame:** `reset`=0 for 2 cycles during `S_FEED` → all outputs 0, `busy`=0. After release, requester 2 (`req_valid`=4'b0100) is granted first.
- **Single frame:** requester 1 sends 8 beats of 7, `add_ready`=1 → `req_ready[1]` high for 8 cycles. Then `res_valid`=1 with `res_id`=1, and `busy`=0 one cycle after `res_ready`.
- **Round-robin:** all four requesters valid continuously → frames are granted in order 0,1,2,3,0, each with exactly 8 beats.
- **Stalls:** `req_valid[3]` low for 3 cycles mid-frame, and `add_ready` low for 2 cycles → `beat_cnt` holds and no other requester's `req_ready` rises. The frame completes after exactly 8 beats.
- **Result backpressure:** `res_ready`=0 for 5 cycles with `add_res_valid`=1 → `add_res_ready`=0 and state stays `S_WAIT_RES`. Pending requests are not granted.
- **`AXI_ADD_SCHED_PRIO_EN` defined:** requesters 0 and 2 both valid continuously → sequence is 0,0,0…. Dropping `req_valid[0]` gives 2 the next grant.

Source files
------------

// File: rtl/axi_add_pkg.sv
// Shared types and helpers for the axi_add frame scheduler.
package axi_add_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_WAIT_RES
  } sched_state_e;

  // Wrap-around increment that stays correct for non-power-of-2 counts.
  function automatic int rr_next(input int ptr, input int n);
    return (ptr >= n - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/axi_add_sched_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, searching upward with wrap.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    idx,
  output logic               vld
);

  int              c;
  logic [ID_W-1:0] ci;

  // Scan from the farthest offset down so the nearest candidate is written last.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    c   = 0;
    ci  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      c = int'(ptr) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      ci = ID_W'(c);
      if (req[ci]) begin
        idx = ci;
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_add_sched.sv
// Frame scheduler sharing one axi_add accumulator between NUM_REQ requesters.
// Optional macro AXI_ADD_SCHED_PRIO_EN: requester 0 gets absolute priority.
module axi_add_sched
  import axi_add_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int N         = 8,
  parameter  int NUM_COUNT = 8,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ*N-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [N-1:0]         add_data,
  output logic                 add_valid,
  input  logic                 add_ready,
  input  logic                 add_res_valid,
  output logic                 add_res_ready,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ID_W-1:0]      res_id,
  output logic                 busy
);

  localparam int CNT_W = $clog2(NUM_COUNT + 1);

  sched_state_e    state, state_nxt;
  logic [ID_W-1:0] grant, grant_nxt;
  logic [ID_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
  logic [ID_W-1:0] pick_idx, sel_id;
  logic            pick_vld;
  logic [N-1:0]    req_slice [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) req_slice[i] = req_data[i*N +: N];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .vld (pick_vld)
  );

`ifdef AXI_ADD_SCHED_PRIO_EN
  assign sel_id = req_valid[0] ? '0 : pick_idx;
`else
  assign sel_id = pick_idx;
`endif

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      rr_ptr   <= rr_ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    rr_ptr_nxt    = rr_ptr;
    beat_cnt_nxt  = beat_cnt;
    req_ready     = '0;
    add_data      = '0;
    add_valid     = 1'b0;
    add_res_ready = 1'b0;
    res_valid     = 1'b0;
    res_id        = '0;
    case (state)
      S_IDLE: begin
        if (pick_vld) begin
          grant_nxt = sel_id;
          state_nxt = S_FEED;
        end
      end
      S_FEED: begin
        add_data         = req_slice[grant];
        add_valid        = req_valid[grant];
        req_ready[grant] = add_ready;
        if (add_valid && add_ready) begin
          if (beat_cnt == CNT_W'(NUM_COUNT - 1)) begin
            beat_cnt_nxt = '0;
            state_nxt    = S_WAIT_RES;
          end else begin
            beat_cnt_nxt = beat_cnt + 1'b1;
          end
        end
      end
      S_WAIT_RES: begin
        res_valid     = add_res_valid;
        add_res_ready = res_ready;
        res_id        = grant;
        if (add_res_valid && res_ready) begin
          state_nxt = S_IDLE;
`ifdef AXI_ADD_SCHED_PRIO_EN
          // Requester-0 frames leave the round-robin position untouched.
          if (grant != '0) rr_ptr_nxt = ID_W'(rr_next(int'(grant), NUM_REQ));
`else
          rr_ptr_nxt = ID_W'(rr_next(int'(grant), NUM_REQ));
`endif
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_add_sched.sv
// Directed scoreboard bench for axi_add_sched; the bench plays requesters, adder and sink.
module tb_axi_add_sched;

  localparam int NUM_REQ   = 4;
  localparam int N         = 8;
  localparam int NUM_COUNT = 8;
  localparam int ID_W      = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NUM_REQ*N-1:0] req_data;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [N-1:0]         add_data;
  logic                 add_valid;
  logic                 add_ready;
  logic                 add_res_valid;
  logic                 add_res_ready;
  logic                 res_valid;
  logic                 res_ready;
  logic [ID_W-1:0]      res_id;
  logic                 busy;

  int n_chk  = 0;
  int n_fail = 0;
  logic [N-1:0] beat_q[$];
  int           id_q[$];

  axi_add_sched #(
    .NUM_REQ   (NUM_REQ),
    .N         (N),
    .NUM_COUNT (NUM_COUNT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_data      (req_data),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .add_data      (add_data),
    .add_valid     (add_valid),
    .add_ready     (add_ready),
    .add_res_valid (add_res_valid),
    .add_res_ready (add_res_ready),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_id        (res_id),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk(tag, {14'd0, busy, req_ready, add_valid, add_data, add_res_ready, res_valid, res_id}, 32'd0);
  endtask

  // Expects a frame for requester id; called before the granting clock edge.
  task automatic frame(input int id, input logic [N-1:0] base, input logic [N-1:0] inc,
                       input bit stall, input int bp);
    int           beats;
    int           cyc_n;
    bit           adv;
    logic [N-1:0] val;
    logic         rv_keep;
    beats   = 0;
    cyc_n   = 0;
    adv     = 1'b0;
    val     = base;
    rv_keep = req_valid[id];
    req_data[id*N +: N] = val;
    beat_q.push_back(val);
    id_q.push_back(id);
    while (beats < NUM_COUNT && cyc_n < 40) begin
      @(negedge clk);
      cyc_n++;
      if (adv) begin
        val = val + inc;
        req_data[id*N +: N] = val;
        beat_q.push_back(val);
        adv = 1'b0;
      end
      if (stall) begin
        add_ready     = !(cyc_n == 3 || cyc_n == 4);
        req_valid[id] = (cyc_n >= 6 && cyc_n <= 8) ? 1'b0 : rv_keep;
      end
      #1;
      chk("other_ready", 32'(req_ready & ~(NUM_REQ'(1) << id)), 32'd0);
      if (!add_ready) chk("stall_ready", 32'(req_ready), 32'd0);
      if (!req_valid[id]) chk("stall_valid", 32'(add_valid), 32'd0);
      if (add_valid && add_ready) begin
        chk("grant_ready", 32'(req_ready), 32'(NUM_REQ'(1) << id));
        if (beat_q.size() > 0) chk("beat_data", 32'(add_data), 32'(beat_q.pop_front()));
        beats++;
        if (beats < NUM_COUNT) adv = 1'b1;
      end
    end
    req_valid[id] = rv_keep;
    add_ready     = 1'b1;
    chk("beat_count", beats, NUM_COUNT);
    chk("feed_cycles", cyc_n, stall ? NUM_COUNT + 5 : NUM_COUNT);
    @(negedge clk); #1;
    chk("wait_no_feed", {27'd0, add_valid, req_ready}, 32'd0);
    chk("wait_busy", 32'(busy), 32'd1);
    chk("wait_res_valid", 32'(res_valid), 32'd0);
    @(negedge clk);
    add_res_valid = 1'b1;
    res_ready     = 1'b0;
    repeat (bp) begin
      #1;
      chk("bp_state", {26'd0, busy, res_valid, add_res_ready, add_valid, res_id}, {26'd0, 4'b1100, 2'(id)});
      chk("bp_no_grant", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    res_ready = 1'b1;
    #1;
    chk("res_valid", 32'(res_valid), 32'd1);
    chk("res_hs_ready", 32'(add_res_ready), 32'd1);
    chk("res_id", 32'(res_id), 32'(id_q.pop_front()));
    @(negedge clk);
    add_res_valid = 1'b0;
    #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_outs", {25'd0, add_valid, req_ready, res_valid, add_res_ready}, 32'd0);
  endtask

  initial begin
    reset         = 1'b0;
    req_valid     = '0;
    req_data      = '0;
    add_ready     = 1'b1;
    add_res_valid = 1'b1;
    res_ready     = 1'b1;
    repeat (2) @(negedge clk);
    #1 chk_reset("reset_init");

    @(negedge clk);
    reset         = 1'b1;
    add_res_valid = 1'b0;
    req_valid     = 4'b0010;
    frame(1, 8'd7, 8'd0, 1'b0, 0);

    req_valid = 4'b1111;
    repeat (3) @(negedge clk);
    reset         = 1'b0;
    add_res_valid = 1'b1;
    #1 chk_reset("reset_mid0");
    @(negedge clk);
    #1 chk_reset("reset_mid1");
    @(negedge clk);
    #1 chk_reset("reset_mid2");
    reset         = 1'b1;
    add_res_valid = 1'b0;
    req_valid     = 4'b0100;
    frame(2, 8'h20, 8'd1, 1'b0, 0);

`ifdef AXI_ADD_SCHED_PRIO_EN
    req_valid = 4'b0101;
    frame(0, 8'h30, 8'd1, 1'b0, 0);
    frame(0, 8'h40, 8'd2, 1'b0, 0);
    frame(0, 8'h50, 8'd3, 1'b0, 0);
    req_valid = 4'b0100;
    frame(2, 8'h60, 8'd1, 1'b0, 0);
`else
    req_valid = 4'b1111;
    frame(3, 8'h30, 8'd1, 1'b0, 0);
    frame(0, 8'h40, 8'd2, 1'b0, 0);
    frame(1, 8'h10, 8'd3, 1'b0, 0);
    frame(2, 8'h90, 8'd1, 1'b0, 0);
    frame(3, 8'hA0, 8'd5, 1'b0, 0);
    req_valid = 4'b1000;
    frame(3, 8'h50, 8'd3, 1'b1, 0);
    req_valid = 4'b0011;
    frame(0, 8'h60, 8'd1, 1'b0, 5);
    frame(1, 8'h70, 8'd1, 1'b0, 0);
    frame(0, 8'hF8, 8'd1, 1'b0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
